// File: rtl/sbox_bram_sched_if.sv
// sbox_bram_sched_if
//   Bundles the round-controller handshake and the dual-port S-box BRAM
//   bus used by sbox_bram_sched.
//
//   Round side : start, page, din, hold -> sequencer
//                busy, done, dout       <- sequencer
//   BRAM side  : bram_en, bram_rst, bram_addra, bram_addrb <- sequencer
//                bram_doa, bram_dob                        -> sequencer
//
//   slave  : the sequencer's view.
//   master : the surrounding system's view (round FSM plus BRAM).
interface sbox_bram_sched_if #(
    parameter int NBYTES = 16
);
    logic                  start;
    logic [1:0]            page;
    logic [8*NBYTES-1:0]   din;
    logic                  hold;
    logic                  busy;
    logic                  done;
    logic [8*NBYTES-1:0]   dout;
    logic                  bram_en;
    logic                  bram_rst;
    logic [9:0]            bram_addra;
    logic [9:0]            bram_addrb;
    logic [7:0]            bram_doa;
    logic [7:0]            bram_dob;

    modport master (
        output start, page, din, hold, bram_doa, bram_dob,
        input  busy, done, dout, bram_en, bram_rst, bram_addra, bram_addrb
    );

    modport slave (
        input  start, page, din, hold, bram_doa, bram_dob,
        output busy, done, dout, bram_en, bram_rst, bram_addra, bram_addrb
    );
endinterface

// File: rtl/sbox_bram_sched.sv
// sbox_bram_sched
//   Sequences one 16-byte masked S-box lookup pass through a dual-port BRAM
//   pair with a 2-cycle registered read. Two bytes are issued per cycle
//   (even byte on port A, odd byte on port B); a valid/index tracker follows
//   each issue through the BRAM and the returning bytes are reassembled in
//   din order into dout. done pulses once the last pair has been captured.
//
//   Ports:
//     clk  - system clock, rising edge
//     rst  - synchronous, active-low reset
//     bus  - sbox_bram_sched_if.slave
//            start/page/din : pass request, latched in IDLE
//            hold           : stall; freezes issue, BRAM pipe and capture
//            busy/done/dout : pass status and result
//            bram_*         : BRAM enable, output reset, addresses, read data
module sbox_bram_sched #(
    parameter int LAT    = 2,
    parameter int NBYTES = 16
) (
    input logic              clk,
    input logic              rst,
    sbox_bram_sched_if.slave bus
);
    localparam int NPAIR = NBYTES / 2;
    localparam int KW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam int W     = 8 * NBYTES;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic          busy_r;
    logic          done_r;
    logic [W-1:0]  dout_r;
    logic [W-1:0]  din_r;
    logic [1:0]    page_r;

    // Tracker: entry 0 is the address register stage, entry LAT-1 lines up
    // with the BRAM output register.
    logic          vld_p [LAT];
    logic [KW-1:0] idx_p [LAT];

    logic en;
    logic issue;
    logic cap;
    logic last_cap;

    function automatic logic [7:0] byte_of(input logic [W-1:0] w,
                                           input int unsigned i);
        return w[8*i +: 8];
    endfunction

    // EN and REGCE share one enable, so a hold freezes the BRAM output
    // register together with the tracker and no read result slips past.
    assign en       = busy_r & ~bus.hold;
    assign issue    = (state == ISSUE) & en;
    assign cap      = vld_p[LAT-1] & en;
    assign last_cap = cap & (idx_p[LAT-1] == KW'(NPAIR - 1));

    assign bus.bram_en  = en;
    assign bus.bram_rst = ~rst;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.dout     = dout_r;

    // Issue stage: addresses follow k and stay put while hold is high.
    always_comb begin
        bus.bram_addra = '0;
        bus.bram_addrb = '0;
        if (state == ISSUE) begin
            bus.bram_addra = {page_r, byte_of(din_r, 2 * 32'(k))};
            bus.bram_addrb = {page_r, byte_of(din_r, 2 * 32'(k) + 1)};
        end
    end

    // Request latch: only taken when a pass is accepted.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            din_r  <= bus.din;
            page_r <= bus.page;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            k      <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dout_r <= '0;
            for (int i = 0; i < LAT; i++) begin
                vld_p[i] <= 1'b0;
                idx_p[i] <= '0;
            end
        end else begin
            done_r <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= ISSUE;
                        busy_r <= 1'b1;
                        k      <= '0;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        // k wraps after the last pair; it is not read again
                        // until the next start clears it.
                        k <= k + 1'b1;
                        if (k == KW'(NPAIR - 1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last_cap) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // BRAM pipeline stages: tracker advances in step with EN/REGCE.
            if (en) begin
                vld_p[0] <= issue;
                idx_p[0] <= k;
                for (int i = 1; i < LAT; i++) begin
                    vld_p[i] <= vld_p[i-1];
                    idx_p[i] <= idx_p[i-1];
                end
            end

            // Capture stage: BRAM output register holds pair idx_p[LAT-1].
            if (cap) begin
                dout_r[16*32'(idx_p[LAT-1]) +: 8]     <= bus.bram_doa;
                dout_r[16*32'(idx_p[LAT-1]) + 8 +: 8] <= bus.bram_dob;
            end
        end
    end
endmodule

// File: tb/tb_sbox_bram_sched.sv
module tb_sbox_bram_sched;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] tmem [1024];
    logic [9:0] ara = '0;
    logic [9:0] arb = '0;
    logic [7:0] doa_r = '0;
    logic [7:0] dob_r = '0;

    sbox_bram_sched_if #(.NBYTES(16)) ifc ();

    sbox_bram_sched #(.LAT(2), .NBYTES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port BRAM: address register then output register,
    // EN and REGCE both driven by bram_en, output reset by bram_rst.
    assign ifc.bram_doa = doa_r;
    assign ifc.bram_dob = dob_r;
    always @(posedge clk) begin
        if (ifc.bram_en) begin
            ara <= ifc.bram_addra;
            arb <= ifc.bram_addrb;
        end
        if (ifc.bram_rst) begin
            doa_r <= '0;
            dob_r <= '0;
        end else if (ifc.bram_en) begin
            doa_r <= tmem[ara];
            dob_r <= tmem[arb];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One pass started in the current cycle (cycle 0). Returns positioned in
    // cycle exp_done+1 without advancing further.
    task automatic run_pass(input string nm, input logic [1:0] pg,
                            input logic [127:0] d, input int hlo, input int hhi,
                            input int exp_done, input int sa, input int sb,
                            input logic [127:0] alt);
        logic [127:0] expd;
        logic [9:0]   ea;
        logic [9:0]   eb;
        logic         h;
        int           iss;
        for (int i = 0; i < 16; i++) expd[8*i +: 8] = tmem[{pg, d[8*i +: 8]}];
        ifc.start = 1'b1;
        ifc.page  = pg;
        ifc.din   = d;
        ifc.hold  = 1'b0;
        tick();
        ifc.start = 1'b0;
        ifc.page  = ~pg;
        ifc.din   = ~d;
        iss = 0;
        for (int c = 1; c <= exp_done; c++) begin
            h = (c >= hlo) && (c <= hhi);
            ifc.hold = h;
            if (c == sa || c == sb) begin
                ifc.start = 1'b1;
                ifc.din   = alt;
            end else begin
                ifc.start = 1'b0;
            end
            #1;
            checks++;
            if (ifc.busy !== (c < exp_done)) begin
                errors++;
                $display("FAIL %s busy c=%0d: got %b want %b", nm, c, ifc.busy, (c < exp_done));
            end
            checks++;
            if (ifc.done !== (c == exp_done)) begin
                errors++;
                $display("FAIL %s done c=%0d: got %b want %b", nm, c, ifc.done, (c == exp_done));
            end
            checks++;
            if (ifc.bram_en !== ((c < exp_done) && !h)) begin
                errors++;
                $display("FAIL %s bram_en c=%0d: got %b want %b", nm, c, ifc.bram_en, ((c < exp_done) && !h));
            end
            if (iss < 8) begin
                ea = {pg, d[16*iss +: 8]};
                eb = {pg, d[16*iss+8 +: 8]};
                checks++;
                if (ifc.bram_addra !== ea || ifc.bram_addrb !== eb) begin
                    errors++;
                    $display("FAIL %s addr c=%0d: got %h/%h want %h/%h", nm, c,
                             ifc.bram_addra, ifc.bram_addrb, ea, eb);
                end
                if (!h) iss++;
            end
            if (c == exp_done) begin
                checks++;
                if (ifc.dout !== expd) begin
                    errors++;
                    $display("FAIL %s dout: got %h want %h", nm, ifc.dout, expd);
                end
            end
            tick();
        end
        ifc.start = 1'b0;
        ifc.hold  = 1'b0;
        #1;
        checks++;
        if (ifc.done !== 1'b0 || ifc.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after-done: got done=%b busy=%b want 0/0", nm, ifc.done, ifc.busy);
        end
        checks++;
        if (ifc.dout !== expd) begin
            errors++;
            $display("FAIL %s dout-hold: got %h want %h", nm, ifc.dout, expd);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ifc.start = 1'b0;
        ifc.hold  = 1'b0;
        ifc.page  = 2'd0;
        ifc.din   = '0;
        tick();
        tick();
        checks++;
        if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.bram_en !== 1'b0) begin
            errors++;
            $display("FAIL reset ctl: got busy=%b done=%b en=%b want 0/0/0", ifc.busy, ifc.done, ifc.bram_en);
        end
        checks++;
        if (ifc.dout !== 128'h0 || ifc.bram_addra !== 10'h0 || ifc.bram_addrb !== 10'h0) begin
            errors++;
            $display("FAIL reset data: got dout=%h a=%h b=%h want 0", ifc.dout, ifc.bram_addra, ifc.bram_addrb);
        end
        checks++;
        if (ifc.bram_rst !== 1'b1) begin
            errors++;
            $display("FAIL reset bram_rst: got %b want 1", ifc.bram_rst);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ifc.bram_rst !== 1'b0) begin
            errors++;
            $display("FAIL reset bram_rst release: got %b want 0", ifc.bram_rst);
        end
        tick();
    endtask

    task automatic test_basic();
        run_pass("basic", 2'd0, 128'h0F0E0D0C0B0A09080706050403020100, 0, -1, 11, -1, -1, '0);
    endtask

    task automatic test_page2_ff();
        tick();
        run_pass("page2", 2'd2, {16{8'hFF}}, 0, -1, 11, -1, -1, '0);
    endtask

    task automatic test_hold();
        tick();
        run_pass("hold", 2'd0, 128'h0F0E0D0C0B0A09080706050403020100, 4, 6, 14, -1, -1, '0);
    endtask

    task automatic test_start_ignored();
        tick();
        run_pass("ignore", 2'd1, 128'h0F0E0D0C0B0A09080706050403020100, 0, -1, 11, 3, 11,
                 128'hA5A4A3A2A1A09F9E9D9C9B9A99989796);
    endtask

    // Starts in the cycle immediately after the previous pass's done.
    task automatic test_back_to_back();
        run_pass("b2b", 2'd3, 128'hA5A4A3A2A1A09F9E9D9C9B9A99989796, 0, -1, 11, -1, -1, '0);
    endtask

    task automatic test_reset_midpass();
        logic seen;
        tick();
        ifc.start = 1'b1;
        ifc.page  = 2'd1;
        ifc.din   = 128'h00112233445566778899AABBCCDDEEFF;
        tick();
        ifc.start = 1'b0;
        for (int c = 1; c < 6; c++) tick();
        rst = 1'b0;
        #1;
        checks++;
        if (ifc.bram_rst !== 1'b1) begin
            errors++;
            $display("FAIL midrst bram_rst: got %b want 1", ifc.bram_rst);
        end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.bram_en !== 1'b0) begin
            errors++;
            $display("FAIL midrst ctl: got busy=%b done=%b en=%b want 0/0/0", ifc.busy, ifc.done, ifc.bram_en);
        end
        checks++;
        if (ifc.dout !== 128'h0 || ifc.bram_addra !== 10'h0 || ifc.bram_addrb !== 10'h0) begin
            errors++;
            $display("FAIL midrst data: got dout=%h a=%h b=%h want 0", ifc.dout, ifc.bram_addra, ifc.bram_addrb);
        end
        seen = 1'b0;
        for (int c = 7; c <= 20; c++) begin
            if (ifc.done === 1'b1 || ifc.busy === 1'b1) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrst no-done: got activity=%b want 0", seen);
        end
        run_pass("afterrst", 2'd0, 128'h0F0E0D0C0B0A09080706050403020100, 0, -1, 11, -1, -1, '0);
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) tmem[a] = 8'((a * 29 + 83) ^ (a >> 2));
        test_reset();
        test_basic();
        test_page2_ff();
        test_hold();
        test_start_ignored();
        test_back_to_back();
        test_reset_midpass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sbox_bram_sched.md
# sbox_bram_sched

Sequencer for one dual-port masked S-box lookup BRAM pair (10-bit address, 8-bit data, registered output, 2-cycle read latency). It takes a 128-bit state share from the round datapath and a 2-bit table page, and issues two byte lookups per cycle on ports A and B. It tracks the in-flight reads and reassembles the 16 results into a 128-bit word, then reports completion to the round controller. It sits between the round FSM and each S-box BRAM instance.

## Interface
- LAT, 2, BRAM read latency in cycles (address register plus output register); fixed for this build
- NBYTES, 16, bytes per state word; must be even
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  reset, synchronous and active-low
- start  in  1  begin one 16-byte pass; sampled only in IDLE
- page  in  2  table select; forms address bits [9:8]; latched at start
- din  in  128  state share; byte i = din[8i+7:8i]; latched at start
- hold  in  1  stall; freezes issue, the BRAM pipeline and capture
- busy  out  1  high in ISSUE and DRAIN
- done  out  1  one-cycle pulse; dout valid from this cycle on
- dout  out  128  looked-up bytes, in the same order as din
- bram_en  out  1  drives BRAM EN and REGCE on both ports
- bram_rst  out  1  active-high BRAM output reset; equal to ~rst
- bram_addra  out  10  port A address {page, byte 2k}
- bram_addrb  out  10  port B address {page, byte 2k+1}
- bram_doa  in  8  port A read data
- bram_dob  in  8  port B read data

## Operation
- FSM states and transitions:
  - IDLE -> ISSUE on start.
  - ISSUE -> DRAIN after the issue with k=7 (NBYTES/2-1).
  - DRAIN -> DONE after the last capture.
  - DONE -> IDLE unconditionally.
- In IDLE, start latches din into a state register and page into a page register, and clears the issue counter k.
- In ISSUE, with hold low:
  - bram_addra = {page_r, state_r byte 2k}.
  - bram_addrb = {page_r, state_r byte 2k+1}.
  - k increments by 1.
- A valid/index shift register of depth LAT follows each issue through the BRAM. It advances only when bram_en is high.
- When the tail entry is valid and bram_en is high, bram_doa is written to dout byte 2·idx and bram_dob to dout byte 2·idx+1.
- bram_en = busy & ~hold.
  - Because EN and REGCE are tied together, hold freezes the BRAM output register and the tracker in lockstep. No data is lost or duplicated.
- k is 3 bits and wraps from 7 to 0. It is not used after the last issue, and no out-of-range address is ever issued.
- dout holds its value from done until the next pass overwrites bytes. Bytes change only on capture.
- start outside IDLE (including during DONE) is ignored. Changes to din/page after start are ignored.
- hold in IDLE or DONE has no effect.
- Reset (rst=0 at an edge) from any state:
  - FSM returns to IDLE.
  - k, the tracker, dout, busy and done clear to 0.
  - bram_en=0, addresses=0.
  - bram_rst=1 while rst=0, which clears the BRAM output registers. An in-flight pass is abandoned and no done is produced.

## Timing
- Reset values: busy=0, done=0, dout=0, bram_en=0, bram_addra=0, bram_addrb=0, bram_rst=1 during reset and 0 after.
- Cycle numbering with start sampled at edge 0 and no hold:
  - Cycles 1–8: ISSUE, pair k=c-1.
  - Data for issue cycle c appears on DO in cycle c+2 and is captured at the end of that cycle, so captures happen in cycles 3–10.
  - Cycles 9–10: DRAIN.
  - Cycle 11: done=1. busy=1 in cycles 1–10.
- Latency from start to done is NBYTES/2+LAT+1 = 11 cycles, plus one cycle for each cycle hold is high while busy.
- Throughput is one pass per 12 cycles. The next start is accepted in the cycle after done (IDLE).

## Test plan
- Reset, then start with page=0, din=0x0F0E…0100, using a behavioural BRAM model with table T -> done exactly in cycle 11, dout byte i = T[{2'b00,i}], busy high in cycles 1–10.
- page=2, din=all 0xFF -> every issued address is 0x2FF; dout = 16 copies of T[0x2FF].
- Same as test 1 with hold high in cycles 4–6 -> done in cycle 14, dout identical to test 1, bram_en low in cycles 4–6, addresses stable during the hold.
- start pulsed again in cycles 3 and 11 with a different din -> both ignored; only the first pass is reported. A start in cycle 12 is accepted, giving done in cycle 23.
- rst=0 in cycle 6 -> cycle 7 shows IDLE, busy=0, dout=0, bram_en=0, and no done appears. A fresh start afterwards completes normally with 11-cycle latency.
